mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester and the load/store requester of the riscv core.
- Sits between the fetch/data stages and the memory model.
- Sequences each transaction with an FSM: request handshake, then read-data return.
- Data accesses have priority. A bounded starvation counter guarantees forward progress for fetch.
- One transaction outstanding at a time.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 4, consecutive arbitration losses fetch tolerates before it is forced to win (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o
- if_addr_i  in  AW  fetch address
- if_gnt_o  out  1  fetch request accepted by memory (1-cycle pulse)
- if_rvalid_o  out  1  fetch read data valid (1-cycle pulse)
- if_rdata_o  out  DW  fetch read data
- dm_req_i  in  1  data request; held with addr/we/wdata stable until dm_gnt_o
- dm_we_i  in  1  1=store, 0=load
- dm_addr_i  in  AW  data address
- dm_wdata_i  in  DW  store data
- dm_gnt_o  out  1  data request accepted (1-cycle pulse)
- dm_rvalid_o  out  1  load data valid (1-cycle pulse)
- dm_rdata_o  out  DW  load data
- mem_req_o  out  1  request to memory
- mem_we_o  out  1  write enable to memory
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_ready_i  in  1  memory accepts the request this cycle
- mem_rvalid_i  in  1  memory read data valid
- mem_rdata_i  in  DW  memory read data
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it forces state IDLE, owner=DATA, wait_cnt=0, and mem_addr_o/mem_wdata_o/mem_we_o registers=0.
- Outputs during and after reset: all outputs 0 while in IDLE.
- FSM states: IDLE, REQ, RDWAIT.
- IDLE, arbitration:
  - If any request is present, choose a winner, latch owner/addr/we/wdata into the mem_* registers, and go to REQ next cycle.
  - Winner rule:
    - fetch if only if_req_i;
    - data if only dm_req_i;
    - both present: fetch if wait_cnt==MAX_WAIT, else data.
- Starvation counter (wait_cnt, width clog2(MAX_WAIT+1)):
  - increments (saturating) when both request and data wins;
  - clears when fetch wins;
  - otherwise holds.
- REQ:
  - mem_req_o=1 with the latched fields.
  - When mem_ready_i=1, pulse the owner's gnt combinationally that cycle.
  - Next state: IDLE if a write, RDWAIT if a read.
  - mem_req_o stays high with fields unchanged while mem_ready_i=0 (no timeout).
- RDWAIT:
  - mem_req_o=0.
  - When mem_rvalid_i=1, pulse owner_rvalid_o combinationally and drive owner_rdata_o=mem_rdata_i, then go to IDLE.
  - The non-owner's rvalid_o stays 0.
  - rdata_o of the non-owner is don't-care; drive it 0.
- Stray mem_rvalid_i outside RDWAIT is ignored.
- mem_rvalid_i in the same cycle as mem_ready_i is not supported; the memory returns data at least 1 cycle after ready.
- Latency (IDLE to IDLE):
  - Read with ready in REQ's first cycle and rvalid 1 cycle later: req seen in cycle 0 (IDLE), gnt in cycle 1, rvalid in cycle 2, back in IDLE in cycle 3.
  - Write: 2 cycles minimum.
- Requests that arrive while not in IDLE wait; they are not queued, only held by the requester.
- Request dropped before gnt: protocol violation, no requirement. The latched transaction still completes.
- Reset mid-transaction: abort immediately. No gnt/rvalid pulse, mem_req_o drops asynchronously. The memory-side transaction is considered lost.
- busy_o = (state != IDLE).

Test Plan:
- Single fetch, addr 0x10, mem_ready_i in REQ cycle 1, rvalid with 0xDEADBEEF the next cycle -> if_gnt_o pulse cycle 1, if_rvalid_o=1 and if_rdata_o=0xDEADBEEF cycle 2, IDLE cycle 3, dm_* outputs stay 0.
- Data store to 0x40, wdata 0x1234, mem_ready_i held 0 for 3 cycles -> mem_req_o/mem_we_o=1, mem_addr_o=0x40 stable 4 cycles; dm_gnt_o one pulse; no rvalid; back to IDLE.
- Both requesting continuously, MAX_WAIT=4, all reads -> grant order D,D,D,D,F,D,D,D,D,F; wait_cnt saturates at 4 then clears.
- rst asserted in RDWAIT, then mem_rvalid_i=1 after release -> no rvalid pulse, busy_o=0, all outputs 0, stray rvalid ignored.
- mem_rvalid_i pulsed while IDLE and while in REQ -> no if/dm rvalid pulse, FSM unaffected.
- Back-to-back data loads 0x0, 0x4 with fixed 1-cycle latency -> each completes in 3 cycles; dm_rdata_o matches the memory model per address.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store.
// Data wins by default; a saturating loss counter eventually forces fetch through.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic          dm_gnt_o,
    output logic          dm_rvalid_o,
    output logic [DW-1:0] dm_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ready_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RDWAIT
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    state_t        state;
    state_t        state_nx;
    owner_t        owner;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_nx;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;

    logic          any_req;
    logic          both_req;
    logic          pick_fetch;

    always_comb begin
        any_req    = if_req_i | dm_req_i;
        both_req   = if_req_i & dm_req_i;
        pick_fetch = if_req_i & (~dm_req_i | (wait_cnt == WAIT_MAX));
    end

    // Only a contested loss counts against fetch; any fetch win resets it.
    always_comb begin
        wait_cnt_nx = wait_cnt;
        if (pick_fetch) begin
            wait_cnt_nx = '0;
        end else if (both_req && wait_cnt != WAIT_MAX) begin
            wait_cnt_nx = wait_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_DATA;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner    <= pick_fetch ? OWN_FETCH : OWN_DATA;
                addr_q   <= pick_fetch ? if_addr_i : dm_addr_i;
                wdata_q  <= pick_fetch ? '0 : dm_wdata_i;
                we_q     <= ~pick_fetch & dm_we_i;
                wait_cnt <= wait_cnt_nx;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_rdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        busy_o      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                if (mem_ready_i) begin
                    if_gnt_o = (owner == OWN_FETCH);
                    dm_gnt_o = (owner == OWN_DATA);
                    state_nx = we_q ? IDLE : RDWAIT;
                end
            end
            RDWAIT: begin
                mem_addr_o = addr_q;
                if (mem_rvalid_i) begin
                    if (owner == OWN_FETCH) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                    end else begin
                        dm_rvalid_o = 1'b1;
                        dm_rdata_o  = mem_rdata_i;
                    end
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions against a
// behavioural arbitration/memory model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_gnt_o    (dm_gnt),
        .dm_rvalid_o (dm_rvalid),
        .dm_rdata_o  (dm_rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ready_i (mem_ready),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;
    int losses  = 0;
    logic [DW-1:0] memm [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet_chk(input string tag);
        chk({tag, ".ctl"}, {57'd0, mem_req, mem_we, if_gnt, dm_gnt,
                            if_rvalid, dm_rvalid, busy}, 64'd0);
        chk({tag, ".addr"}, {32'd0, mem_addr}, 64'd0);
        chk({tag, ".wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, ".rdata"}, {if_rdata, dm_rdata}, 64'd0);
    endtask

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        if (memm.exists(a)) return memm[a];
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE: the model decides the winner from the
    // current requests and the count of contested losses fetch has taken.
    task automatic run_txn(input int rdy_dly, input int rv_dly,
                           input bit stray, input bit drop,
                           output bit got_fetch, output int cycles);
        bit            f;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rdv;
        if (if_req && dm_req) f = (losses >= MW);
        else f = if_req;
        if (f) losses = 0;
        else if (if_req) losses = (losses < MW) ? losses + 1 : MW;
        a  = f ? if_addr : dm_addr;
        we = !f && dm_we;
        wd = dm_wdata;
        got_fetch = 1'b0;
        cycles = 1;
        #1;
        chk("idle.busy", {63'd0, busy}, 64'd0);
        chk("idle.mem_req", {63'd0, mem_req}, 64'd0);
        tick();
        for (int i = 0; i <= rdy_dly; i++) begin
            mem_ready  = (i == rdy_dly);
            mem_rvalid = stray && (i != rdy_dly);
            mem_rdata  = 32'hBAD0BAD0;
            #1;
            chk("req.mem_req", {63'd0, mem_req}, 64'd1);
            chk("req.busy", {63'd0, busy}, 64'd1);
            chk("req.addr", {32'd0, mem_addr}, {32'd0, a});
            chk("req.we", {63'd0, mem_we}, {63'd0, we});
            if (we) chk("req.wdata", {32'd0, mem_wdata}, {32'd0, wd});
            chk("req.gnt", {62'd0, if_gnt, dm_gnt},
                (i == rdy_dly) ? (f ? 64'd2 : 64'd1) : 64'd0);
            chk("req.rvalid", {62'd0, if_rvalid, dm_rvalid}, 64'd0);
            if (i == rdy_dly) begin
                got_fetch = if_gnt;
                if (we) memm[a] = wd;
            end
            tick();
            cycles++;
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        if (drop) begin
            if (f) if_req = 1'b0;
            else dm_req = 1'b0;
        end
        if (!we) begin
            rdv = rd(a);
            for (int j = 0; j <= rv_dly; j++) begin
                mem_rvalid = (j == rv_dly);
                mem_rdata  = (j == rv_dly) ? rdv : 32'h5555AAAA;
                #1;
                chk("rd.mem_req", {63'd0, mem_req}, 64'd0);
                chk("rd.busy", {63'd0, busy}, 64'd1);
                chk("rd.gnt", {62'd0, if_gnt, dm_gnt}, 64'd0);
                chk("rd.rvalid", {62'd0, if_rvalid, dm_rvalid},
                    (j == rv_dly) ? (f ? 64'd2 : 64'd1) : 64'd0);
                if (j == rv_dly)
                    chk("rd.rdata", {32'd0, f ? if_rdata : dm_rdata},
                        {32'd0, rdv});
                chk("rd.other", {32'd0, f ? dm_rdata : if_rdata}, 64'd0);
                tick();
                cycles++;
            end
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        #1;
        chk("done.busy", {63'd0, busy}, 64'd0);
    endtask

    bit gf;
    int cyc;

    initial begin
        rst        = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        memm[32'h10] = 32'hDEADBEEF;
        memm[32'h0]  = 32'h11112222;
        memm[32'h4]  = 32'h33334444;
        #2;
        quiet_chk("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        quiet_chk("post_reset");

        // single fetch
        if_req  = 1'b1;
        if_addr = 32'h10;
        run_txn(0, 0, 1'b0, 1'b1, gf, cyc);
        chk("t1.cycles", 64'(cyc), 64'd3);
        chk("t1.owner", {63'd0, gf}, 64'd1);

        // store with slow ready
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h40;
        dm_wdata = 32'h1234;
        run_txn(3, 0, 1'b0, 1'b1, gf, cyc);
        chk("t2.cycles", 64'(cyc), 64'd5);
        dm_we = 1'b0;
        quiet_chk("t2.idle");

        // both requesting continuously
        if_req  = 1'b1;
        dm_req  = 1'b1;
        if_addr = 32'h100;
        dm_addr = 32'h200;
        for (int k = 0; k < 10; k++) begin
            run_txn(0, 0, 1'b0, 1'b0, gf, cyc);
            chk("t3.order", {63'd0, gf}, (k % 5 == 4) ? 64'd1 : 64'd0);
        end
        if_req = 1'b0;
        dm_req = 1'b0;

        // reset in RDWAIT, then a stray rvalid
        if_req  = 1'b1;
        if_addr = 32'h20;
        tick();
        mem_ready = 1'b1;
        #1;
        chk("t4.gnt", {63'd0, if_gnt}, 64'd1);
        tick();
        mem_ready = 1'b0;
        if_req    = 1'b0;
        #1;
        chk("t4.rdwait", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        quiet_chk("t4.rst");
        losses = 0;
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        #1;
        quiet_chk("t4.stray");
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1;
        quiet_chk("t4.after");

        // stray rvalid in IDLE and in REQ
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        #1;
        quiet_chk("t5.idle");
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        dm_req     = 1'b1;
        dm_addr    = 32'h8;
        run_txn(2, 1, 1'b1, 1'b1, gf, cyc);
        chk("t5.cycles", 64'(cyc), 64'd6);

        // back-to-back loads
        dm_req  = 1'b1;
        dm_addr = 32'h0;
        run_txn(0, 0, 1'b0, 1'b0, gf, cyc);
        chk("t6.cycles0", 64'(cyc), 64'd3);
        dm_addr = 32'h4;
        run_txn(0, 0, 1'b0, 1'b1, gf, cyc);
        chk("t6.cycles1", 64'(cyc), 64'd3);

        // random traffic
        for (int it = 0; it < 300; it++) begin
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dm_req && $urandom_range(0, 2) != 0) begin
                dm_req   = 1'b1;
                dm_addr  = 32'($urandom_range(0, 15)) << 2;
                dm_we    = 1'($urandom_range(0, 1));
                dm_wdata = $urandom;
            end
            if (if_req || dm_req) begin
                run_txn($urandom_range(0, 3), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'b1, gf, cyc);
            end else begin
                #1;
                quiet_chk("rnd.idle");
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
